// File: rtl/packetmem_pingpong.sv
// Double-buffered packet memory: a 32-bit writer fills one buffer while the
// BPF interpreter reads the other with big-endian 8/16/32-bit bounded reads.
module packetmem_pingpong #(
    parameter int BYTE_ADDR_WIDTH = 12,
    parameter int ADDR_WIDTH      = BYTE_ADDR_WIDTH - 2,
    parameter int LEN_WIDTH       = BYTE_ADDR_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [31:0]                idata,
    input  logic                       wr_en,
    input  logic                       wr_done,
    input  logic [LEN_WIDTH-1:0]       wr_len,
    output logic                       wr_ready,
    input  logic [BYTE_ADDR_WIDTH-1:0] rd_addr,
    input  logic [1:0]                 sz,
    input  logic                       rd_en,
    output logic [31:0]                odata,
    output logic                       rd_valid,
    output logic                       rd_oob,
    output logic                       pkt_ready,
    output logic [LEN_WIDTH-1:0]       pkt_len,
    input  logic                       rd_release
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_FULL  = 2'd2,
        BUF_READ  = 2'd3
    } buf_state_e;

    localparam int BANK_AW    = ADDR_WIDTH - 1;
    localparam int BANK_DEPTH = 1 << BANK_AW;
    localparam int SUM_W      = LEN_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << BYTE_ADDR_WIDTH;

    buf_state_e           state_q   [2];
    buf_state_e           state_d   [2];
    logic [LEN_WIDTH-1:0] len_q     [2];
    logic [LEN_WIDTH-1:0] len_d     [2];
    logic                 w_sel_q, w_sel_d;
    logic                 r_sel_q, r_sel_d;
    logic [LEN_WIDTH-1:0] pkt_len_q, pkt_len_d;

    logic                 wr_accept;
    logic                 wr_commit;
    logic                 rd_accept;
    logic                 rd_commit;
    logic [LEN_WIDTH-1:0] wr_len_sat;

    assign wr_ready   = (state_q[w_sel_q] == BUF_FILL);
    assign pkt_ready  = (state_q[r_sel_q] == BUF_READ);
    assign pkt_len    = pkt_len_q;
    assign wr_accept  = wr_en && wr_ready;
    assign wr_commit  = wr_done && wr_ready;
    assign rd_accept  = rd_en && pkt_ready;
    assign rd_commit  = rd_release && pkt_ready;
    assign wr_len_sat = (wr_len > MAX_LEN) ? MAX_LEN : wr_len;

    // Writer and reader only ever touch buffers in disjoint states, so their updates never collide.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        w_sel_d   = w_sel_q;
        r_sel_d   = r_sel_q;
        pkt_len_d = pkt_len_q;

        if (wr_commit) begin
            state_d[w_sel_q] = BUF_FULL;
            len_d[w_sel_q]   = wr_len_sat;
            w_sel_d          = ~w_sel_q;
            if (state_q[~w_sel_q] == BUF_EMPTY) begin
                state_d[~w_sel_q] = BUF_FILL;
            end
        end else if (state_q[w_sel_q] == BUF_EMPTY) begin
            state_d[w_sel_q] = BUF_FILL;
        end

        if (rd_commit) begin
            state_d[r_sel_q] = BUF_EMPTY;
            r_sel_d          = ~r_sel_q;
        end else if (state_q[r_sel_q] == BUF_FULL) begin
            state_d[r_sel_q] = BUF_READ;
            pkt_len_d        = len_q[r_sel_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= BUF_FILL;
            state_q[1] <= BUF_EMPTY;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            w_sel_q    <= 1'b0;
            r_sel_q    <= 1'b0;
            pkt_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            w_sel_q   <= w_sel_d;
            r_sel_q   <= r_sel_d;
            pkt_len_q <= pkt_len_d;
        end
    end

    // Even/odd word banks let the two adjacent words of a window be fetched in one cycle.
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [BANK_AW-1:0]    rd_idx_hi;
    logic [BANK_AW-1:0]    rd_even_idx;
    logic [BANK_AW-1:0]    rd_odd_idx;
    logic [BANK_AW-1:0]    wr_idx;

    assign rd_word     = rd_addr[BYTE_ADDR_WIDTH-1:2];
    assign rd_idx_hi   = rd_word[ADDR_WIDTH-1:1];
    assign rd_even_idx = rd_word[0] ? (rd_idx_hi + BANK_AW'(1)) : rd_idx_hi;
    assign rd_odd_idx  = rd_idx_hi;
    assign wr_idx      = wr_addr[ADDR_WIDTH-1:1];

    for (genvar b = 0; b < 2; b++) begin : g_buf
        logic [31:0] even_mem [BANK_DEPTH];
        logic [31:0] odd_mem  [BANK_DEPTH];
        logic [31:0] rd_even_q;
        logic [31:0] rd_odd_q;

        always_ff @(posedge clk) begin
            if (wr_accept && (w_sel_q == 1'(b))) begin
                if (wr_addr[0]) begin
                    odd_mem[wr_idx] <= idata;
                end else begin
                    even_mem[wr_idx] <= idata;
                end
            end
            if (rd_accept && (r_sel_q == 1'(b))) begin
                rd_even_q <= even_mem[rd_even_idx];
                rd_odd_q  <= odd_mem[rd_odd_idx];
            end
        end
    end

    logic [2:0]       rd_nbytes;
    logic [SUM_W-1:0] rd_end;
    logic             rd_oob_now;

    always_comb begin
        rd_nbytes = 3'd1;
        case (sz)
            2'b00:   rd_nbytes = 3'd4;
            2'b01:   rd_nbytes = 3'd2;
            default: rd_nbytes = 3'd1;
        endcase
    end

    assign rd_end     = SUM_W'(rd_addr) + SUM_W'(rd_nbytes);
    assign rd_oob_now = rd_end > SUM_W'(pkt_len_q);

    logic       rd_valid_q, rd_valid_d;
    logic       rd_oob_q, rd_oob_d;
    logic       rd_zero_q, rd_zero_d;
    logic [1:0] rd_off_q, rd_off_d;
    logic [1:0] rd_sz_q, rd_sz_d;
    logic       rd_upper_odd_q, rd_upper_odd_d;
    logic       rd_buf_q, rd_buf_d;

    // rd_zero_q keeps odata at zero from reset and after an out-of-bounds read until a good read lands.
    always_comb begin
        rd_valid_d     = 1'b0;
        rd_oob_d       = 1'b0;
        rd_zero_d      = rd_zero_q;
        rd_off_d       = rd_off_q;
        rd_sz_d        = rd_sz_q;
        rd_upper_odd_d = rd_upper_odd_q;
        rd_buf_d       = rd_buf_q;
        if (rd_accept) begin
            rd_valid_d     = 1'b1;
            rd_oob_d       = rd_oob_now;
            rd_zero_d      = rd_oob_now;
            rd_off_d       = rd_addr[1:0];
            rd_sz_d        = sz;
            rd_upper_odd_d = rd_word[0];
            rd_buf_d       = r_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q     <= 1'b0;
            rd_oob_q       <= 1'b0;
            rd_zero_q      <= 1'b1;
            rd_off_q       <= 2'd0;
            rd_sz_q        <= 2'd0;
            rd_upper_odd_q <= 1'b0;
            rd_buf_q       <= 1'b0;
        end else begin
            rd_valid_q     <= rd_valid_d;
            rd_oob_q       <= rd_oob_d;
            rd_zero_q      <= rd_zero_d;
            rd_off_q       <= rd_off_d;
            rd_sz_q        <= rd_sz_d;
            rd_upper_odd_q <= rd_upper_odd_d;
            rd_buf_q       <= rd_buf_d;
        end
    end

    logic [31:0] even_sel;
    logic [31:0] odd_sel;
    logic [31:0] upper_word;
    logic [31:0] lower_word;
    logic [31:0] window;
    logic [31:0] extracted;

    assign even_sel   = rd_buf_q ? g_buf[1].rd_even_q : g_buf[0].rd_even_q;
    assign odd_sel    = rd_buf_q ? g_buf[1].rd_odd_q  : g_buf[0].rd_odd_q;
    assign upper_word = rd_upper_odd_q ? odd_sel : even_sel;
    assign lower_word = rd_upper_odd_q ? even_sel : odd_sel;

    always_comb begin
        window = upper_word;
        case (rd_off_q)
            2'd0: window = upper_word;
            2'd1: window = {upper_word[23:0], lower_word[31:24]};
            2'd2: window = {upper_word[15:0], lower_word[31:16]};
            2'd3: window = {upper_word[7:0],  lower_word[31:8]};
            default: window = upper_word;
        endcase
    end

    always_comb begin
        extracted = {24'd0, window[31:24]};
        case (rd_sz_q)
            2'b00:   extracted = window;
            2'b01:   extracted = {16'd0, window[31:16]};
            default: extracted = {24'd0, window[31:24]};
        endcase
    end

    assign odata    = rd_zero_q ? 32'd0 : extracted;
    assign rd_valid = rd_valid_q;
    assign rd_oob   = rd_oob_q;

endmodule

// File: tb/tb_packetmem_pingpong.sv
// Scoreboard bench for packetmem_pingpong: expected reads come from a byte-level
// model of each buffer and are matched against rd_valid results in order.
module tb_packetmem_pingpong;

    localparam int BAW = 12;
    localparam int AW  = BAW - 2;
    localparam int LW  = BAW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   idata = '0;
    logic          wr_en = 1'b0;
    logic          wr_done = 1'b0;
    logic [LW-1:0] wr_len = '0;
    logic          wr_ready;
    logic [BAW-1:0] rd_addr = '0;
    logic [1:0]    sz = 2'b00;
    logic          rd_en = 1'b0;
    logic [31:0]   odata;
    logic          rd_valid;
    logic          rd_oob;
    logic          pkt_ready;
    logic [LW-1:0] pkt_len;
    logic          rd_release = 1'b0;

    packetmem_pingpong #(
        .BYTE_ADDR_WIDTH(BAW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_addr   (wr_addr),
        .idata     (idata),
        .wr_en     (wr_en),
        .wr_done   (wr_done),
        .wr_len    (wr_len),
        .wr_ready  (wr_ready),
        .rd_addr   (rd_addr),
        .sz        (sz),
        .rd_en     (rd_en),
        .odata     (odata),
        .rd_valid  (rd_valid),
        .rd_oob    (rd_oob),
        .pkt_ready (pkt_ready),
        .pkt_len   (pkt_len),
        .rd_release(rd_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        oob;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    sb_entry_t   mon_entry;
    logic [31:0] model_mem [2][1024];
    int          checks = 0;
    int          failures = 0;
    int          cur_rbuf = 0;
    int          cur_len = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        wr_done    = 1'b0;
        rd_en      = 1'b0;
        rd_release = 1'b0;
    endtask

    function automatic void expRead(input int addr, input logic [1:0] s, input int b, input int len,
                                    output logic [31:0] data, output logic oob);
        int n;
        int a;
        logic [31:0] w;
        n = (s == 2'b00) ? 4 : ((s == 2'b01) ? 2 : 1);
        data = 32'd0;
        oob = 1'b0;
        if (addr + n > len) begin
            oob = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                a = (addr + i) % (1 << BAW);
                w = model_mem[b][a / 4];
                data = (data << 8) | ((w >> (8 * (3 - (a % 4)))) & 32'hFF);
            end
        end
    endfunction

    task automatic pushExpected(input string tag, input int addr, input logic [1:0] s);
        sb_entry_t e;
        e.tag = tag;
        expRead(addr, s, cur_rbuf, cur_len, e.data, e.oob);
        sb_q.push_back(e);
    endtask

    task automatic writeWord(input int b, input int addr, input logic [31:0] data,
                             input bit done, input int len);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        idata   = data;
        if (done) begin
            wr_done = 1'b1;
            wr_len  = LW'(len);
        end
        model_mem[b][addr] = data;
        applyStimulus();
    endtask

    task automatic readReq(input string tag, input int addr, input logic [1:0] s, input bit accept);
        rd_en   = 1'b1;
        rd_addr = BAW'(addr);
        sz      = s;
        if (accept) pushExpected(tag, addr, s);
        applyStimulus();
        checkOutput({tag, "_valid"}, 32'(rd_valid), 32'(accept));
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_entry = sb_q.pop_front();
                checkOutput({mon_entry.tag, "_data"}, odata, mon_entry.data);
                checkOutput({mon_entry.tag, "_oob"}, 32'(rd_oob), 32'(mon_entry.oob));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    int          rd_addrs_a [8] = '{1, 3, 7, 5, 7, 6, 7, 7};
    logic [1:0]  rd_szs_a   [8] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11};
    int          rd_addrs_b [4] = '{0, 1, 3, 2};
    logic [1:0]  rd_szs_b   [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
    int          rd_addrs_c [7] = '{0, 4, 4092, 4095, 4094, 4094, 4095};
    logic [1:0]  rd_szs_c   [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("rst_pkt_ready", 32'(pkt_ready), 32'd0);
        checkOutput("rst_odata", odata, 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_rd_oob", 32'(rd_oob), 32'd0);
        checkOutput("rst_pkt_len", 32'(pkt_len), 32'd0);
        rst_n = 1'b1;
        applyStimulus();

        readReq("rd_no_pkt", 0, 2'b00, 1'b0);

        // First packet into buf0, buf1 takes over filling without a gap
        writeWord(0, 0, 32'h00010203, 1'b0, 0);
        writeWord(0, 1, 32'h04050607, 1'b1, 8);
        checkOutput("pkt_ready_early", 32'(pkt_ready), 32'd0);
        checkOutput("wr_ready_buf1", 32'(wr_ready), 32'd1);
        applyStimulus();
        checkOutput("pkt_ready_p0", 32'(pkt_ready), 32'd1);
        checkOutput("pkt_len_p0", 32'(pkt_len), 32'd8);
        cur_rbuf = 0;
        cur_len  = 8;

        for (int i = 0; i < 8; i++) begin
            readReq($sformatf("p0_rd%0d", i), rd_addrs_a[i], rd_szs_a[i], 1'b1);
        end

        // buf1 completes with write and done in the same cycle while buf0 is still read
        writeWord(1, 0, 32'hA0B0C0D0, 1'b1, 4);
        checkOutput("wr_ready_stall", 32'(wr_ready), 32'd0);
        checkOutput("pkt_len_hold", 32'(pkt_len), 32'd8);

        wr_en   = 1'b1;
        wr_addr = AW'(1);
        idata   = 32'hDEADBEEF;
        wr_done = 1'b1;
        wr_len  = LW'(12);
        applyStimulus();
        checkOutput("ignored_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("ignored_pkt_len", 32'(pkt_len), 32'd8);

        rd_en      = 1'b1;
        rd_addr    = BAW'(0);
        sz         = 2'b00;
        rd_release = 1'b1;
        pushExpected("rel_rd", 0, 2'b00);
        applyStimulus();
        checkOutput("rel_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("rel_pkt_ready", 32'(pkt_ready), 32'd0);
        checkOutput("rel_wr_ready", 32'(wr_ready), 32'd0);
        readReq("rd_gap", 0, 2'b00, 1'b0);
        checkOutput("p1_pkt_ready", 32'(pkt_ready), 32'd1);
        checkOutput("p1_pkt_len", 32'(pkt_len), 32'd4);
        checkOutput("rel_wr_ready2", 32'(wr_ready), 32'd1);
        cur_rbuf = 1;
        cur_len  = 4;

        for (int i = 0; i < 4; i++) begin
            readReq($sformatf("p1_rd%0d", i), rd_addrs_b[i], rd_szs_b[i], 1'b1);
        end

        // Refill buf0 with an oversize length that must saturate
        writeWord(0, 0, 32'h11223344, 1'b0, 0);
        writeWord(0, 1023, 32'hCAFEF00D, 1'b1, 5000);
        checkOutput("p2_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("p2_pkt_len_old", 32'(pkt_len), 32'd4);
        rd_release = 1'b1;
        applyStimulus();
        checkOutput("p2_pkt_ready_drop", 32'(pkt_ready), 32'd0);
        applyStimulus();
        checkOutput("p2_pkt_ready", 32'(pkt_ready), 32'd1);
        checkOutput("p2_pkt_len_sat", 32'(pkt_len), 32'd4096);
        checkOutput("p2_wr_ready_buf1", 32'(wr_ready), 32'd1);
        cur_rbuf = 0;
        cur_len  = 4096;

        for (int i = 0; i < 7; i++) begin
            readReq($sformatf("p2_rd%0d", i), rd_addrs_c[i], rd_szs_c[i], 1'b1);
        end

        // Reset lands while back-to-back reads are in flight
        readReq("b2b_rd0", 0, 2'b00, 1'b1);
        readReq("b2b_rd1", 4, 2'b00, 1'b1);
        readReq("b2b_rd2", 8, 2'b10, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("midrst_pkt_ready", 32'(pkt_ready), 32'd0);
        checkOutput("midrst_odata", odata, 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("postrst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("postrst_pkt_ready", 32'(pkt_ready), 32'd0);
        checkOutput("postrst_pkt_len", 32'(pkt_len), 32'd0);

        writeWord(0, 0, 32'h55667788, 1'b1, 4);
        applyStimulus();
        checkOutput("p3_pkt_ready", 32'(pkt_ready), 32'd1);
        checkOutput("p3_pkt_len", 32'(pkt_len), 32'd4);
        cur_rbuf = 0;
        cur_len  = 4;
        readReq("p3_rd0", 0, 2'b00, 1'b1);
        readReq("p3_rd1", 2, 2'b01, 1'b1);
        readReq("p3_rd2", 1, 2'b10, 1'b1);
        readReq("p3_rd3", 3, 2'b00, 1'b1);

        repeat (3) applyStimulus();
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packetmem_pingpong.md
Name: packetmem_pingpong

Overview:
- Parametrised successor to the single-buffer packet memory: two packet buffers ping-pong between a 32-bit packet writer and the BPF interpreter's read port.
- The writer fills one buffer while the interpreter reads the other. Buffers swap ownership through a done/release handshake.
- The read port supports big-endian 8/16/32-bit reads from any byte address, with a packet-length bounds check.

Parameters:
- BYTE_ADDR_WIDTH, 12: byte address width per buffer; each buffer holds 2^BYTE_ADDR_WIDTH bytes.
- ADDR_WIDTH, BYTE_ADDR_WIDTH-2: word address width; memory is 32 bits wide.
- LEN_WIDTH, BYTE_ADDR_WIDTH+1: width of packet length, so a completely full buffer is representable.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_addr  in  ADDR_WIDTH  word address within the writer's current buffer.
- idata  in  32  write data, big-endian byte order.
- wr_en  in  1  write strobe.
- wr_done  in  1  1-cycle pulse marking end of packet.
- wr_len  in  LEN_WIDTH  packet byte length, sampled with wr_done.
- wr_ready  out  1  writer owns a buffer in FILL state.
- rd_addr  in  BYTE_ADDR_WIDTH  byte address for a read.
- sz  in  2  read size: 00 word, 01 half-word, 10 byte; 11 is treated as byte.
- rd_en  in  1  read strobe.
- odata  out  32  read result, zero-padded on the left.
- rd_valid  out  1  odata valid; asserted 1 cycle after an accepted rd_en.
- rd_oob  out  1  accompanies rd_valid; the read exceeded the packet length.
- pkt_ready  out  1  reader holds a buffer in READ state.
- pkt_len  out  LEN_WIDTH  length of the packet held by the reader.
- rd_release  in  1  1-cycle pulse; reader finished with its buffer.

Behaviour:
- Per-buffer state: EMPTY, FILL, FULL, READ. Pointers: w_sel (writer's buffer) and r_sel (reader's buffer).
- Reset values:
  - buf0 in FILL, buf1 in EMPTY; w_sel=0, r_sel=0.
  - Stored lengths are 0.
  - wr_ready=1, pkt_ready=0, odata=0, rd_valid=0, rd_oob=0, pkt_len=0.
  - Memory contents are not reset.
- Write path:
  - wr_en with wr_ready: idata is written to buffer w_sel at wr_addr.
  - wr_en without wr_ready: ignored.
- wr_done with wr_ready:
  - Buffer w_sel goes to FULL; its length latches wr_len, saturated to 2^BYTE_ADDR_WIDTH.
  - w_sel toggles. The other buffer enters FILL on the next edge if it is EMPTY. Otherwise wr_ready stays low until that buffer is released.
  - wr_en and wr_done in the same cycle: the write lands in the completing buffer.
- wr_done without wr_ready: ignored.
- Reader acquire: when the reader holds no buffer and buffer r_sel is FULL, that buffer becomes READ. pkt_ready rises and pkt_len is loaded 1 cycle after it became FULL.
- rd_release with pkt_ready:
  - Buffer goes to EMPTY, r_sel toggles, pkt_ready drops next cycle.
  - If the writer is stalled on this buffer, it enters FILL one cycle later; wr_ready rises 2 cycles after the release.
- rd_release without pkt_ready: ignored.
- wr_done and rd_release in the same cycle: both take effect. Packet order is strictly alternating buf0, buf1, buf0, …
- Read path:
  - rd_en with pkt_ready: read word rd_addr[BAW-1:2] and word +1 (wrapping), registered. Select the 32-bit window at byte offset rd_addr[1:0] from the 64-bit concatenation, upper word first. Extract by sz as in the prior block: W = window; H = window[31:16]; B = window[31:24].
  - Latency: rd_en at edge N produces odata/rd_valid at edge N+1.
  - odata holds its value until the next accepted read.
  - rd_valid is a single-cycle pulse per accepted read. Back-to-back reads give one result per cycle.
  - Bounds check: rd_oob=1 and odata=0 when rd_addr + nbytes(sz) > pkt_len. The sum is computed in LEN_WIDTH+1 bits, with no wrap.
  - rd_en without pkt_ready: no read, rd_valid stays 0.
  - rd_en on the same cycle as rd_release: the read completes on the old buffer.
- Port conflict: write and read target different buffers by construction, so there is no arbitration. The two RAMs are independent dual-port blocks.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous); in-flight rd_valid is dropped.

Test Plan:
- Reset, write words 0x00010203, 0x04050607 at addresses 0,1, wr_done with wr_len=8 -> pkt_ready=1 two cycles later, pkt_len=8, wr_ready stays 1 (buf1 FILL).
- On that packet: read W at addr 1 -> odata=0x01020304; H at addr 3 -> 0x00000304; B at addr 7 -> 0x00000007; each with rd_valid one cycle after rd_en, rd_oob=0.
- Read W at addr 5 with pkt_len=8 -> rd_oob=1, odata=0. Read B at addr 7 -> rd_oob=0.
- Complete buf1 (wr_len=4) while buf0 is still READ -> wr_ready=0. Then rd_release -> reader acquires buf1 (pkt_len=4), buf0 enters FILL, and wr_ready=1 two cycles after the release.
- With wr_ready=0, pulse wr_en and wr_done -> no state change and no memory change, verified by later reads.
- Assert rst_n=0 during back-to-back reads -> rd_valid and pkt_ready clear immediately; after release, wr_ready=1 and w_sel=0.
